// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the prefetching instruction-fetch buffer:
// FSM state encoding, default FIFO depth and the sequential PC increment.
package inst_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    IFB_STATE_IDLE  = 2'b00,
    IFB_STATE_REQ   = 2'b01,
    IFB_STATE_DRAIN = 2'b10
  } ifb_state_e;

  localparam int unsigned IFB_DEPTH = 4;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Synchronous FIFO holding {instPc, inst} pairs; clear empties it in one edge.
// The head word reads as zero while the FIFO is empty.
module ifb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != DEPTH_W);
    do_pop   = pop && (count_q != '0);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Prefetching fetch front end: issues sequential word reads over a req/ack bus,
// queues the responses and presents the head instruction with its PC.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned           PC_LENGTH   = 32,
  parameter int unsigned           INST_LENGTH = 32,
  parameter int unsigned           DEPTH       = IFB_DEPTH,
  parameter logic [PC_LENGTH-1:0]  RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetchEn,
  input  logic                    instRd,
  input  logic                    flush,
  input  logic [PC_LENGTH-1:0]    flushPc,
  output logic [INST_LENGTH-1:0]  inst,
  output logic [PC_LENGTH-1:0]    instPc,
  output logic                    instValid,
  output logic                    memReq,
  output logic [PC_LENGTH-1:0]    memAddr,
  input  logic                    memAck,
  input  logic [INST_LENGTH-1:0]  memData
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  ifb_state_e             state_q, state_d;
  logic [PC_LENGTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                   mem_req_q, mem_req_d;
  logic [PC_LENGTH-1:0]   mem_addr_q, mem_addr_d;

  logic                   fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [PC_LENGTH+INST_LENGTH-1:0] fifo_head;
  logic [CW:0]            occupancy;
  logic                   space_ok;

  // The outstanding word reserves a slot so a later push can never overflow.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q == IFB_STATE_REQ)};
    space_ok  = (occupancy < DEPTH_W);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fifo_push  = 1'b0;
    case (state_q)
      IFB_STATE_IDLE: begin
        if (flush) begin
          fetch_pc_d = flushPc;
        end else if (fetchEn && space_ok) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_LENGTH'(PC_INC);
          state_d    = IFB_STATE_REQ;
        end
      end
      IFB_STATE_REQ: begin
        if (memAck) begin
          mem_req_d = 1'b0;
          state_d   = IFB_STATE_IDLE;
          if (flush) begin
            fetch_pc_d = flushPc;
          end else begin
            fifo_push = 1'b1;
          end
        end else if (flush) begin
          fetch_pc_d = flushPc;
          state_d    = IFB_STATE_DRAIN;
        end
      end
      IFB_STATE_DRAIN: begin
        if (flush) begin
          fetch_pc_d = flushPc;
        end
        if (memAck) begin
          mem_req_d = 1'b0;
          state_d   = IFB_STATE_IDLE;
        end
      end
      default: begin
        state_d   = IFB_STATE_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
    fifo_pop = instRd && !fifo_empty && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFB_STATE_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  ifb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_LENGTH + INST_LENGTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .din   ({mem_addr_q, memData}),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign inst      = fifo_head[INST_LENGTH-1:0];
  assign instPc    = fifo_head[INST_LENGTH +: PC_LENGTH];
  assign instValid = !fifo_empty;
  assign memReq    = mem_req_q;
  assign memAddr   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: a behavioural memory answers
// requests, a scoreboard queue predicts the FIFO head and request addresses.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetchEn = 1'b1;
  logic        instRd = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flushPc = '0;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        instValid;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memData = '0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(
    .PC_LENGTH   (32),
    .INST_LENGTH (32),
    .DEPTH       (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetchEn   (fetchEn),
    .instRd    (instRd),
    .flush     (flush),
    .flushPc   (flushPc),
    .inst      (inst),
    .instPc    (instPc),
    .instValid (instValid),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memAck    (memAck),
    .memData   (memData)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] sb[$];
  logic [31:0] exp_addr = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] flush_target = '0;
  bit          req_seen = 0;
  bit          discard = 0;
  bit          flush_cmd = 0;
  bit          rd_cmd = 0;
  bit          flush_on_ack = 0;
  bit          fa_hit = 0;
  int unsigned wait_cnt = 0;
  int unsigned lat = 2;

  task automatic step();
    @(negedge clk);
    check("instValid", instValid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("headPc", instPc, sb[0][63:32]);
      check("headInst", inst, sb[0][31:0]);
    end else begin
      check("emptyHead", {instPc, inst}, 64'h0);
    end
    if (memAck) begin
      memAck   = 1'b0;
      req_seen = 0;
      check("reqDrop", memReq, 1'b0);
    end
    if (req_seen) begin
      check("reqHold", {memReq, memAddr}, {1'b1, req_addr});
    end else if (memReq) begin
      check("memAddr", memAddr, exp_addr);
      req_addr = exp_addr;
      exp_addr = exp_addr + 32'd4;
      req_seen = 1;
      wait_cnt = 0;
    end
    if (req_seen) begin
      if (wait_cnt == lat) begin
        memAck  = 1'b1;
        memData = memAddr ^ 32'hFFFF_0000;
      end else begin
        wait_cnt++;
      end
    end
    flushPc = flush_target;
    flush   = flush_cmd || (flush_on_ack && memAck);
    if (flush_on_ack && memAck) fa_hit = 1;
    instRd  = rd_cmd;
    if (instRd && sb.size() != 0 && !flush) void'(sb.pop_front());
    if (memAck) begin
      if (!flush && !discard) sb.push_back({req_addr, req_addr ^ 32'hFFFF_0000});
      discard = 0;
    end
    if (flush) begin
      sb.delete();
      exp_addr = flushPc;
      if (req_seen && !memAck) discard = 1;
    end
  endtask

  task automatic reset_dut();
    #1 rst = 1'b1;
    #1;
    check("rstMemReq", memReq, 1'b0);
    check("rstMemAddr", memAddr, 32'h0);
    check("rstValid", instValid, 1'b0);
    check("rstHead", {instPc, inst}, 64'h0);
    sb.delete();
    exp_addr = '0;
    req_seen = 0;
    discard  = 0;
    wait_cnt = 0;
    memAck   = 1'b0;
    flush    = 1'b0;
    instRd   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_dut();
    step();
    check("firstReq", memReq, 1'b1);

    // fill to DEPTH, then no further requests
    for (int i = 0; i < 100 && sb.size() < 4; i++) step();
    if (sb.size() < 4) check("fill_timeout", sb.size(), 4);
    repeat (6) begin
      step();
      check("fullNoReq", memReq, 1'b0);
    end
    check("fullHeadInst", inst, 32'hFFFF_0000);
    check("fullHeadPc", instPc, 32'h0);

    // single pop frees a slot; refill request follows
    rd_cmd = 1; step(); rd_cmd = 0;
    step();
    check("popHeadPc", instPc, 32'h4);
    check("popNoReqYet", memReq, 1'b0);
    step();
    check("refillReq", memReq, 1'b1);
    check("refillAddr", memAddr, 32'h10);

    // asynchronous reset while the request to 16 is outstanding
    reset_dut();
    step();
    check("firstReq2", memReq, 1'b1);

    // flush while request for 8 is pending; its response must be dropped
    lat = 3;
    for (int i = 0; i < 200 && !(req_seen && req_addr == 32'h8); i++) step();
    if (!(req_seen && req_addr == 32'h8)) check("req8_timeout", req_addr, 32'h8);
    flush_target = 32'h100;
    flush_cmd = 1; step(); flush_cmd = 0;
    for (int i = 0; i < 200 && sb.size() == 0; i++) step();
    if (sb.size() == 0) check("flushPush_timeout", sb.size(), 1);
    step();
    check("flushHeadPc", instPc, 32'h100);

    // flush coinciding with memAck
    flush_target = 32'h200;
    flush_on_ack = 1;
    for (int i = 0; i < 200 && !fa_hit; i++) step();
    flush_on_ack = 0;
    if (!fa_hit) check("flushAck_timeout", fa_hit, 1);
    step();
    check("faIdle", memReq, 1'b0);
    check("faEmpty", instValid, 1'b0);
    step();
    check("faReq", memReq, 1'b1);
    check("faAddr", memAddr, 32'h200);

    // address wrap at the top of the space
    flush_target = 32'hFFFF_FFFC;
    flush_cmd = 1; step(); flush_cmd = 0;
    for (int i = 0; i < 200 && !(req_seen && req_addr == 32'h0); i++) step();
    if (!(req_seen && req_addr == 32'h0)) check("wrap_timeout", req_addr, 32'h0);
    check("wrapAddr", memAddr, 32'h0);

    // stop prefetching, drain everything, keep popping an empty FIFO
    fetchEn = 1'b0;
    rd_cmd = 1;
    repeat (20) step();
    check("drainedValid", instValid, 1'b0);
    check("drainedReq", memReq, 1'b0);
    step();
    check("emptyPopValid", instValid, 1'b0);
    rd_cmd = 0;
    fetchEn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Prefetching instruction-fetch front end between the CPU fetch port and a multi-cycle instruction memory bus with a req/ack handshake.
- Fetches sequential words ahead of the core into a small FIFO and presents the head instruction with its PC and a valid flag.
- Sits directly upstream of the ID stage and replaces the single-cycle ROM path.
- Supports redirect (flush) from a later stage, including discarding an in-flight response.

Parameters:
PC_LENGTH, 32, width of PCs and memory addresses
INST_LENGTH, 32, instruction width
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
fetchEn  input  1  1 = prefetching allowed; 0 = no new requests (in-flight request completes)
instRd  input  1  core pops the FIFO head this cycle
flush  input  1  redirect: discard FIFO and in-flight data, restart at flushPc
flushPc  input  PC_LENGTH  redirect target
inst  output  INST_LENGTH  FIFO head instruction (0 when empty)
instPc  output  PC_LENGTH  PC of head instruction (0 when empty)
instValid  output  1  FIFO non-empty
memReq  output  1  memory request, registered
memAddr  output  PC_LENGTH  request address, registered
memAck  input  1  memory completes the current request; memData valid this cycle
memData  input  INST_LENGTH  returned instruction word

Behaviour:
- Reset (async, immediate): memReq=0, memAddr=RESET_PC, FIFO empty, instValid=0, inst=0, instPc=0, fetchPc=RESET_PC, state=IDLE.
- Bus rules: one outstanding request at most. memReq and memAddr stay stable from assertion until the cycle memAck=1. memReq drops on the edge after ack. memAck while memReq=0 is ignored.
- State IDLE:
  - Issue when fetchEn=1 and count < DEPTH and flush=0.
  - On issue: memReq<=1, memAddr<=fetchPc, fetchPc<=fetchPc+4 (wraps modulo 2^PC_LENGTH), go to REQ.
  - First request is asserted on the first clock edge after rst deasserts.
- State REQ:
  - On memAck with flush=0: push {memData, memAddr}, memReq<=0. A new request is not issued the same edge; go to IDLE. Sustained throughput is 1 word per (bus latency + 1) cycles.
  - On flush without memAck: fetchPc<=flushPc, FIFO cleared, go to DRAIN with memReq/memAddr held.
  - On flush with memAck in the same cycle: data discarded, fetchPc<=flushPc, FIFO cleared, memReq<=0, go to IDLE.
- State DRAIN:
  - Hold request until memAck, then discard memData, memReq<=0, go to IDLE.
  - A further flush in DRAIN only updates fetchPc.
- Flush in IDLE: FIFO cleared, fetchPc<=flushPc, no issue that edge.
- Space check: count + outstanding never exceeds DEPTH. Issue is only allowed when count < DEPTH, and the outstanding word counts as reserved, so the condition is count + (state==REQ) < DEPTH. Push therefore never overflows.
- Pop:
  - instRd with instValid=1 removes the head on the edge.
  - instRd when empty is ignored.
  - Push and pop on the same edge keeps count unchanged.
  - instRd in a flush cycle is ignored (flush wins).
- Output timing: inst/instPc/instValid are driven from registered FIFO state. Data acked in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
- Ordering: FIFO output is strictly in request order, and instPc of consecutive entries differs by 4 unless separated by a flush.
- fetchEn=0 mid-REQ: the request completes and is pushed normally.

Decomposition:
- Shared header MIPS.vh gains:
  - IFB_STATE_IDLE/REQ/DRAIN 2-bit encodings
  - IFB_DEPTH default
  - PC_INC (4)
- Reuse the existing PC_LENGTH and INST_LENGTH.
- Sub-module ifb_fifo: synchronous FIFO of {instPc, inst}, DEPTH entries, with push/pop/clear, count and empty outputs, and asynchronous active-high reset.
- The top holds the FSM, fetchPc and the bus registers.

Test Plan:
- Reset release, fetchEn=1, memory acks 2 cycles after each req with data=addr^32'hFFFF_0000 -> memAddr sequence 0,4,8,12. FIFO fills to 4, then memReq stays 0. Head inst=32'hFFFF_0000, instPc=0.
- FIFO full, instRd=1 for one cycle -> count 3, new request to 16 issued next edge, head instPc=4.
- Flush with flushPc=32'h100 while REQ for addr 8 is pending, ack 3 cycles later -> that response is discarded, instValid=0 until the first new push, next memAddr=32'h100, first head instPc=32'h100.
- Flush and memAck in the same cycle -> no push, IDLE, next memAddr=flushPc one edge later.
- fetchPc=32'hFFFF_FFFC -> next request addr 0 (wrap); pop on an empty FIFO leaves count 0.
- Assert rst mid-REQ -> memReq=0, memAddr=RESET_PC and instValid=0 immediately, before the next clock edge.
